// File: rtl/flash_boot_loader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// flash_boot_loader_pkg : shared types and constants for the boot loader
// Rev 1.0
// ---------------------------------------------------------------------------
package flash_boot_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_DATA = 3'd2,
        S_FIN  = 3'd3,
        S_DONE = 3'd4
    } boot_state_e;

    localparam logic [7:0] FLASH_READ_CMD = 8'h03;
    localparam int         CMD_BITS       = 32;

    // Flash streams byte 0 first; memory wants byte 0 in the low lane.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/flash_boot_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// flash_boot_loader_if : SPI flash pins plus instruction-memory write port
// Rev 1.0
// ---------------------------------------------------------------------------
interface flash_boot_loader_if;
    logic        sck_o;
    logic        cs_no;
    logic        mosi_o;
    logic        miso_i;
    logic        write_o;
    logic [12:0] addr_o;
    logic [31:0] data_o;
    logic        done_o;

    modport master (
        output sck_o, cs_no, mosi_o, write_o, addr_o, data_o, done_o,
        input  miso_i
    );

    modport slave (
        input  sck_o, cs_no, mosi_o, write_o, addr_o, data_o, done_o,
        output miso_i
    );
endinterface
`default_nettype wire

// File: rtl/flash_boot_loader_sck_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// flash_boot_loader_sck_gen : SPI mode-0 clock divider with edge strobes
// Rev 1.0
// ---------------------------------------------------------------------------
module flash_boot_loader_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  wire  clk_i,
    input  wire  rst_ni,
    input  wire  en,
    output logic sck,
    output logic rise,
    output logic fall
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic          sck_q;
    logic          term;

    assign term = (div_cnt == CW'(CLK_DIV - 1));
    // Strobes mark the clk edge at which sck is about to change.
    assign rise = en && term && !sck_q;
    assign fall = en && term &&  sck_q;
    assign sck  = sck_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt <= '0;
            sck_q   <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            sck_q   <= 1'b0;
        end else if (term) begin
            div_cnt <= '0;
            sck_q   <= ~sck_q;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/flash_boot_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// flash_boot_loader : copies a boot image from SPI NOR flash into instr RAM
// Rev 1.0
// ---------------------------------------------------------------------------
module flash_boot_loader
    import flash_boot_loader_pkg::*;
#(
    parameter int          CLK_DIV    = 2,
    parameter logic [23:0] FLASH_BASE = 24'h0,
    parameter int          WORDS      = 2048
) (
    input  wire                 clk_i,
    input  wire                 rst_ni,
    flash_boot_loader_if.master bus
);
    localparam int                FIN_W     = $clog2(CLK_DIV + 1);
    localparam logic [FIN_W-1:0]  FIN_LAST  = FIN_W'(CLK_DIV - 1);
    localparam logic [11:0]       LAST_WORD = 12'(WORDS - 1);
    localparam logic [CMD_BITS-1:0] CMD_WORD = {FLASH_READ_CMD, FLASH_BASE};

    boot_state_e state, state_next;

    logic             sck, sck_en, sck_rise, sck_fall;
    logic [4:0]       bit_cnt;
    logic [11:0]      word_cnt;
    logic [30:0]      cmd_sh;
    logic [30:0]      rx_sh;
    logic [FIN_W-1:0] fin_cnt;
    logic             cs_n, mosi, write_en, done;
    logic [12:0]      addr;
    logic [31:0]      data;
    logic             last_bit, last_word;
    logic [31:0]      rx_word;

    assign last_bit  = (bit_cnt == 5'd31);
    assign last_word = (word_cnt == LAST_WORD);
    assign rx_word   = {rx_sh, bus.miso_i};

    // In FIN the divider runs only long enough to bring sck back low.
    assign sck_en = (state == S_CMD) || (state == S_DATA) || ((state == S_FIN) && sck);

    flash_boot_loader_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en     (sck_en),
        .sck    (sck),
        .rise   (sck_rise),
        .fall   (sck_fall)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: state_next = S_CMD;
            S_CMD:  if (sck_fall && last_bit) state_next = S_DATA;
            S_DATA: if (sck_rise && last_bit && last_word) state_next = S_FIN;
            S_FIN:  if (!sck && (fin_cnt == FIN_LAST)) state_next = S_DONE;
            S_DONE: state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
            cmd_sh   <= '0;
            rx_sh    <= '0;
            fin_cnt  <= '0;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            write_en <= 1'b0;
            addr     <= '0;
            data     <= '0;
            done     <= 1'b0;
        end else begin
            write_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    cs_n     <= 1'b0;
                    cmd_sh   <= CMD_WORD[30:0];
                    mosi     <= CMD_WORD[31];
                    bit_cnt  <= '0;
                    word_cnt <= '0;
                end
                // Command bits advance on sck fall; the 32nd fall hands over to DATA.
                S_CMD: if (sck_fall) begin
                    cmd_sh  <= {cmd_sh[29:0], 1'b0};
                    mosi    <= last_bit ? 1'b0 : cmd_sh[30];
                    bit_cnt <= bit_cnt + 5'd1;
                end
                S_DATA: if (sck_rise) begin
                    rx_sh   <= rx_word[30:0];
                    bit_cnt <= bit_cnt + 5'd1;
                    if (last_bit) begin
                        write_en <= 1'b1;
                        data     <= bswap32(rx_word);
                        addr     <= {word_cnt[10:0], 2'b00};
                        if (!last_word) word_cnt <= word_cnt + 12'd1;
                    end
                end
                S_FIN: if (!sck) begin
                    if (fin_cnt == FIN_LAST) cs_n <= 1'b1;
                    else                     fin_cnt <= fin_cnt + FIN_W'(1);
                end
                S_DONE: done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.sck_o   = sck;
    assign bus.cs_no   = cs_n;
    assign bus.mosi_o  = mosi;
    assign bus.write_o = write_en;
    assign bus.addr_o  = addr;
    assign bus.data_o  = data;
    assign bus.done_o  = done;
endmodule
`default_nettype wire

// File: tb/tb_flash_boot_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_flash_boot_loader : four loader instances, each with a SPI flash model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_flash_boot_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rst_n;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0]  done_v, cs_v, sck_v, mosi_v, wr_v;
    logic [12:0] addr_v [4];
    logic [31:0] data_v [4];

    // Flash contents: low address byte, xored with a tag from the high nibble.
    function automatic logic [7:0] fbyte(input logic [23:0] a);
        return a[7:0] ^ {a[23:20], a[23:20]};
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_inst
        localparam int          DIV  = (gi == 1) ? 3 : (gi == 3) ? 1 : 2;
        localparam logic [23:0] BASE = (gi == 2) ? 24'h100000 : 24'h0;
        localparam int          NW   = (gi == 0) ? 4 : (gi == 1) ? 3 : (gi == 2) ? 2 : 8;

        flash_boot_loader_if ifc();

        flash_boot_loader #(.CLK_DIV(DIV), .FLASH_BASE(BASE), .WORDS(NW)) u_dut (
            .clk_i  (clk),
            .rst_ni (rst_n[gi]),
            .bus    (ifc)
        );

        assign done_v[gi] = ifc.done_o;
        assign cs_v[gi]   = ifc.cs_no;
        assign sck_v[gi]  = ifc.sck_o;
        assign mosi_v[gi] = ifc.mosi_o;
        assign wr_v[gi]   = ifc.write_o;
        assign addr_v[gi] = ifc.addr_o;
        assign data_v[gi] = ifc.data_o;

        int          fl_cnt = 0;
        int          fl_out = 0;
        logic [31:0] fl_cmd = '0;
        logic [7:0]  fl_byte;
        initial ifc.miso_i = 1'b0;

        always @(posedge ifc.sck_o or posedge ifc.cs_no) begin
            if (ifc.cs_no) fl_cnt = 0;
            else if (fl_cnt < 32) begin
                fl_cmd = {fl_cmd[30:0], ifc.mosi_o};
                fl_cnt++;
            end
        end

        always @(negedge ifc.sck_o or posedge ifc.cs_no) begin
            if (ifc.cs_no) begin
                fl_out     = 0;
                ifc.miso_i = 1'b0;
            end else if (fl_cnt >= 32) begin
                fl_byte    = fbyte(fl_cmd[23:0] + 24'(fl_out / 8));
                ifc.miso_i = fl_byte[7 - (fl_out % 8)];
                fl_out++;
            end
        end

        int          wr_cnt, post_done, width_err, rise_cnt, bad_period, mosi_bad;
        int          last_rise, first_rise, last_fall, cs_fall, cs_rise;
        logic [12:0] wr_addr [16];
        logic [31:0] wr_data [16];
        int          wr_cyc  [16];
        logic        prev_wr, prev_sck, prev_cs;

        always @(negedge clk) begin
            if (!rst_n[gi]) begin
                wr_cnt = 0; post_done = 0; width_err = 0; rise_cnt = 0;
                bad_period = 0; mosi_bad = 0; last_rise = 0; first_rise = 0;
                last_fall = 0; cs_fall = 0; cs_rise = 0;
                prev_wr = 1'b0; prev_sck = 1'b0; prev_cs = 1'b1;
            end else begin
                if (ifc.write_o) begin
                    if (wr_cnt < 16) begin
                        wr_addr[wr_cnt] = ifc.addr_o;
                        wr_data[wr_cnt] = ifc.data_o;
                        wr_cyc[wr_cnt]  = cyc;
                    end
                    wr_cnt++;
                    if (ifc.done_o) post_done++;
                    if (prev_wr) width_err++;
                end
                if (ifc.sck_o && !prev_sck) begin
                    if (rise_cnt > 0 && (cyc - last_rise) != 2 * DIV) bad_period++;
                    if (rise_cnt == 0) first_rise = cyc;
                    last_rise = cyc;
                    rise_cnt++;
                end
                if (!ifc.sck_o && prev_sck) last_fall = cyc;
                if (!ifc.cs_no && prev_cs) cs_fall = cyc;
                if (ifc.cs_no && !prev_cs) cs_rise = cyc;
                if (!ifc.cs_no && fl_cnt >= 32 && ifc.mosi_o) mosi_bad++;
                prev_wr  = ifc.write_o;
                prev_sck = ifc.sck_o;
                prev_cs  = ifc.cs_no;
            end
        end
    end

    task automatic wait_done(input int i);
        int c;
        c = 0;
        while (!done_v[i] && c < 5000) begin
            @(negedge clk);
            c++;
        end
        vectors++;
        if (!done_v[i]) begin
            $display("FAIL done_timeout[%0d]: done_o=%b required 1 within 5000 cycles", i, done_v[i]);
            miscompares++;
        end
        repeat (20) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({cs_v[i], sck_v[i], mosi_v[i], wr_v[i], done_v[i], addr_v[i], data_v[i]}
                !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0, 32'h0}) begin
                $display("FAIL reset[%0d]: cs=%b sck=%b mosi=%b wr=%b done=%b addr=%h data=%h required cs=1 rest 0",
                         i, cs_v[i], sck_v[i], mosi_v[i], wr_v[i], done_v[i], addr_v[i], data_v[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp_tab [4];
        exp_tab = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        wait_done(0);
        vectors++;
        if (g_inst[0].fl_cmd !== 32'h03000000) begin
            $display("FAIL basic_cmd: got %h required 03000000", g_inst[0].fl_cmd);
            miscompares++;
        end
        vectors++;
        if (g_inst[0].wr_cnt !== 4) begin
            $display("FAIL basic_count: got %0d required 4", g_inst[0].wr_cnt);
            miscompares++;
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (g_inst[0].wr_addr[k] !== 13'(4 * k) || g_inst[0].wr_data[k] !== exp_tab[k]) begin
                $display("FAIL basic_write[%0d]: got (%h,%h) required (%h,%h)", k,
                         g_inst[0].wr_addr[k], g_inst[0].wr_data[k], 13'(4 * k), exp_tab[k]);
                miscompares++;
            end
        end
        vectors++;
        if ({done_v[0], cs_v[0], sck_v[0], mosi_v[0], wr_v[0]} !== 5'b11000) begin
            $display("FAIL basic_idle: done,cs,sck,mosi,wr=%b required 11000",
                     {done_v[0], cs_v[0], sck_v[0], mosi_v[0], wr_v[0]});
            miscompares++;
        end
        vectors++;
        if (g_inst[0].post_done !== 0 || g_inst[0].width_err !== 0) begin
            $display("FAIL basic_strobe: post_done=%0d width_err=%0d required 0 0",
                     g_inst[0].post_done, g_inst[0].width_err);
            miscompares++;
        end
    endtask

    task automatic test_spacing();
        wait_done(1);
        vectors++;
        if (g_inst[1].wr_cnt !== 3) begin
            $display("FAIL spacing_count: got %0d required 3", g_inst[1].wr_cnt);
            miscompares++;
        end
        for (int k = 1; k < 3; k++) begin
            vectors++;
            if (g_inst[1].wr_cyc[k] - g_inst[1].wr_cyc[k-1] !== 192) begin
                $display("FAIL spacing_gap[%0d]: got %0d required 192", k,
                         g_inst[1].wr_cyc[k] - g_inst[1].wr_cyc[k-1]);
                miscompares++;
            end
        end
        vectors++;
        if (g_inst[1].rise_cnt !== 128 || g_inst[1].bad_period !== 0 || g_inst[1].width_err !== 0) begin
            $display("FAIL spacing_sck: rises=%0d bad_period=%0d width_err=%0d required 128 0 0",
                     g_inst[1].rise_cnt, g_inst[1].bad_period, g_inst[1].width_err);
            miscompares++;
        end
        vectors++;
        if (g_inst[1].wr_data[2] !== 32'h0B0A0908) begin
            $display("FAIL spacing_data: got %h required 0B0A0908", g_inst[1].wr_data[2]);
            miscompares++;
        end
    endtask

    task automatic test_base();
        wait_done(2);
        vectors++;
        if (g_inst[2].fl_cmd !== 32'h03100000) begin
            $display("FAIL base_cmd: got %h required 03100000", g_inst[2].fl_cmd);
            miscompares++;
        end
        vectors++;
        if (g_inst[2].wr_cnt !== 2 || g_inst[2].wr_addr[0] !== 13'h0 || g_inst[2].wr_data[0] !== 32'h12131011) begin
            $display("FAIL base_word0: cnt=%0d got (%h,%h) required 2 (0000,12131011)",
                     g_inst[2].wr_cnt, g_inst[2].wr_addr[0], g_inst[2].wr_data[0]);
            miscompares++;
        end
        vectors++;
        if (g_inst[2].wr_addr[1] !== 13'h4 || g_inst[2].wr_data[1] !== 32'h16171415) begin
            $display("FAIL base_word1: got (%h,%h) required (0004,16171415)",
                     g_inst[2].wr_addr[1], g_inst[2].wr_data[1]);
            miscompares++;
        end
    endtask

    task automatic test_clk_div1();
        wait_done(3);
        vectors++;
        if (g_inst[3].wr_cnt !== 8) begin
            $display("FAIL div1_count: got %0d required 8", g_inst[3].wr_cnt);
            miscompares++;
        end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (g_inst[3].wr_addr[k] !== 13'(4 * k) || g_inst[3].wr_data[k] !== exp_word(24'(4 * k))) begin
                $display("FAIL div1_write[%0d]: got (%h,%h) required (%h,%h)", k,
                         g_inst[3].wr_addr[k], g_inst[3].wr_data[k], 13'(4 * k), exp_word(24'(4 * k)));
                miscompares++;
            end
        end
        vectors++;
        if (g_inst[3].first_rise - g_inst[3].cs_fall < 1 || g_inst[3].cs_rise - g_inst[3].last_fall < 1) begin
            $display("FAIL div1_cs_timing: setup=%0d hold=%0d required >=1 >=1",
                     g_inst[3].first_rise - g_inst[3].cs_fall, g_inst[3].cs_rise - g_inst[3].last_fall);
            miscompares++;
        end
        vectors++;
        if (g_inst[3].rise_cnt !== 288 || g_inst[3].bad_period !== 0 || g_inst[3].mosi_bad !== 0) begin
            $display("FAIL div1_sck: rises=%0d bad_period=%0d mosi_bad=%0d required 288 0 0",
                     g_inst[3].rise_cnt, g_inst[3].bad_period, g_inst[3].mosi_bad);
            miscompares++;
        end
    endtask

    task automatic test_abort();
        int c;
        @(negedge clk);
        rst_n[3] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n[3] = 1'b1;
        c = 0;
        while (g_inst[3].wr_cnt < 5 && c < 5000) begin
            @(negedge clk);
            c++;
        end
        vectors++;
        if (cs_v[3] !== 1'b0 || g_inst[3].wr_cnt < 5) begin
            $display("FAIL abort_pre: cs=%b writes=%0d required cs=0 writes>=5", cs_v[3], g_inst[3].wr_cnt);
            miscompares++;
        end
        #2;
        rst_n[3] = 1'b0;
        #1;
        vectors++;
        if ({cs_v[3], sck_v[3], mosi_v[3], wr_v[3], done_v[3], addr_v[3], data_v[3]}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0, 32'h0}) begin
            $display("FAIL abort_async: cs=%b sck=%b mosi=%b wr=%b done=%b addr=%h data=%h required cs=1 rest 0",
                     cs_v[3], sck_v[3], mosi_v[3], wr_v[3], done_v[3], addr_v[3], data_v[3]);
            miscompares++;
        end
        repeat (3) @(negedge clk);
        rst_n[3] = 1'b1;
        wait_done(3);
        vectors++;
        if (g_inst[3].wr_cnt !== 8 || g_inst[3].wr_addr[0] !== 13'h0 || g_inst[3].wr_data[0] !== 32'h03020100) begin
            $display("FAIL abort_restart: cnt=%0d first=(%h,%h) required 8 (0000,03020100)",
                     g_inst[3].wr_cnt, g_inst[3].wr_addr[0], g_inst[3].wr_data[0]);
            miscompares++;
        end
        vectors++;
        if (g_inst[3].wr_addr[7] !== 13'h1C || g_inst[3].wr_data[7] !== 32'h1F1E1D1C) begin
            $display("FAIL abort_last: got (%h,%h) required (001c,1f1e1d1c)",
                     g_inst[3].wr_addr[7], g_inst[3].wr_data[7]);
            miscompares++;
        end
    endtask

    initial begin
        rst_n = 4'b0000;
        repeat (4) @(negedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 4'b1111;
        test_basic();
        test_spacing();
        test_base();
        test_clk_div1();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
